// File: rtl/vedic_mult_pipe.sv
// rtl/vedic_mult_pipe.sv - fully pipelined recursive Vedic (Urdhva-Tiryagbhyam) multiplier
//
// Computes WIDTH x WIDTH -> 2*WIDTH. The product is built as a tree: 2x2 products
// first, then 4x4 from four 2x2 results, and so on up to WIDTH. There is one register
// stage per tree level, so LAT = log2(WIDTH) cycles from accept to out_valid.
//
// Optional feature macro: VEDIC_SIGNED_EN
//   defined   : the op_signed port exists. op_signed=1 treats a and b as two's complement.
//               Stage 0 takes magnitudes, the sign rides down the pipe, and the final
//               stage negates the result.
//   undefined : unsigned only. There is no op_signed port.
//
// Parameters
//   WIDTH      operand width; power of two, 4..32
//   TAG_W      sideband tag width (>=1)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; discards everything in flight
//   in_valid   operand pair valid
//   in_ready   pipe can accept this cycle (= ~stall, independent of in_valid)
//   a, b       multiplicand / multiplier
//   in_tag     sideband tag carried with the pair
//   op_signed  two's-complement mode (VEDIC_SIGNED_EN only)
//   out_valid  product valid
//   out_ready  downstream accepts product
//   p          product, 2*WIDTH bits
//   out_tag    tag of the pair that produced p

module vedic_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef VEDIC_SIGNED_EN
    input  logic               op_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int LAT = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 32 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("vedic_mult_pipe: WIDTH must be a power of two in 4..32");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("vedic_mult_pipe: TAG_W must be >= 1");
    end

    // 2x2 Urdhva step: vertical a0b0, crosswise a1b0+a0b1, vertical a1b1 plus carry.
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic v0, x1y0, x0y1, c1, v1;
        v0   = x[0] & y[0];
        x1y0 = x[1] & y[0];
        x0y1 = x[0] & y[1];
        c1   = x1y0 & x0y1;
        v1   = x[1] & y[1];
        return {v1 & c1, v1 ^ c1, x1y0 ^ x0y1, v0};
    endfunction

    // Backpressure is a single global stall: all stages hold together while the
    // product at the output is waiting.
    logic stall;
    logic advance;

    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    // Operand conditioning (stage 0, combinational)
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef VEDIC_SIGNED_EN
    logic           neg_in;
    logic [LAT-1:1] neg_q;

    // Magnitude of -2^(W-1) is 2^(W-1), which fits as an unsigned WIDTH-bit value.
    assign a_mag  = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (op_signed && b[WIDTH-1]) ? -b : b;
    assign neg_in = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

    // The sign is needed only as input to the last stage, so it is piped through
    // stages 1..LAT-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= '0;
        end else if (advance) begin
            neg_q[1] <= neg_in;
            for (int s = 2; s < LAT; s++) begin
                neg_q[s] <= neg_q[s-1];
            end
        end
    end
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // Product tree: level k holds D*D sub-products of N-bit chunks (N = 2^k).
    // Sub-product (i,j) is chunk i of a times chunk j of b. It is 2N bits wide and
    // packed at offset (i*D + j)*2N.
    for (genvar k = 1; k <= LAT; k++) begin : g_lvl
        localparam int N  = 1 << k;
        localparam int D  = WIDTH / N;
        localparam int QW = 2 * N * D * D;

        logic [QW-1:0] nxt;
        logic [QW-1:0] q;

        if (k == 1) begin : g_leaf
            for (genvar i = 0; i < D; i++) begin : g_i
                for (genvar j = 0; j < D; j++) begin : g_j
                    assign nxt[(i*D+j)*4 +: 4] = vedic2x2(a_mag[2*i +: 2], b_mag[2*j +: 2]);
                end
            end
        end else begin : g_node
            localparam int H  = N / 2;
            localparam int PD = 2 * D;

            for (genvar i = 0; i < D; i++) begin : g_i
                for (genvar j = 0; j < D; j++) begin : g_j
                    logic [N-1:0]   ll;
                    logic [N-1:0]   lh;
                    logic [N-1:0]   hl;
                    logic [N-1:0]   hh;
                    logic [N:0]     mid;
                    logic [2*N-1:0] sum;

                    // Halves from the previous level. Each is an N-bit product of H-bit chunks.
                    assign ll = g_lvl[k-1].q[((2*i)  *PD + 2*j  )*N +: N];
                    assign lh = g_lvl[k-1].q[((2*i)  *PD + 2*j+1)*N +: N];
                    assign hl = g_lvl[k-1].q[((2*i+1)*PD + 2*j  )*N +: N];
                    assign hh = g_lvl[k-1].q[((2*i+1)*PD + 2*j+1)*N +: N];

                    // The crosswise sum keeps its carry. {hh,ll} places HH<<N and LL directly.
                    assign mid = {1'b0, lh} + {1'b0, hl};
                    assign sum = {hh, ll} + ({{(N-1){1'b0}}, mid} << H);

`ifdef VEDIC_SIGNED_EN
                    if (k == LAT) begin : g_neg
                        assign nxt[(i*D+j)*2*N +: 2*N] = neg_q[LAT-1] ? -sum : sum;
                    end else begin : g_pass
                        assign nxt[(i*D+j)*2*N +: 2*N] = sum;
                    end
`else
                    assign nxt[(i*D+j)*2*N +: 2*N] = sum;
`endif
                end
            end
        end

        // Data registers load even for bubbles. out_valid masks stale contents.
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (advance) begin
                q <= nxt;
            end
        end
    end

    // Valid bits and tags travel with the data.
    logic [LAT:1]     vld_q;
    logic [TAG_W-1:0] tag_q [1:LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 1; s <= LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else if (advance) begin
            vld_q    <= {vld_q[LAT-1:1], in_valid};
            tag_q[1] <= in_tag;
            for (int s = 2; s <= LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[LAT];
    assign out_tag   = tag_q[LAT];
    assign p         = g_lvl[LAT].q;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb/tb_vedic_mult_pipe.sv - directed self-checking bench for vedic_mult_pipe
module tb_vedic_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic [3:0]  out_tag;
`ifdef VEDIC_SIGNED_EN
    logic        op_signed;
`endif

    logic        v4, r4, o4;
    logic [3:0]  a4, b4, t4;
    logic [7:0]  p4;
    logic        v16, r16, o16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic [3:0]  t16;
    logic        v32, r32, o32;
    logic [31:0] a32, b32;
    logic [63:0] p32;
    logic [3:0]  t32;

    vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag),
`ifdef VEDIC_SIGNED_EN
        .op_signed(op_signed),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .p(p), .out_tag(out_tag)
    );

    vedic_mult_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
        .a(a4), .b(b4), .in_tag(4'd0),
`ifdef VEDIC_SIGNED_EN
        .op_signed(1'b0),
`endif
        .out_valid(o4), .out_ready(1'b1), .p(p4), .out_tag(t4)
    );

    vedic_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
        .a(a16), .b(b16), .in_tag(4'd0),
`ifdef VEDIC_SIGNED_EN
        .op_signed(1'b0),
`endif
        .out_valid(o16), .out_ready(1'b1), .p(p16), .out_tag(t16)
    );

    vedic_mult_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32),
        .a(a32), .b(b32), .in_tag(4'd0),
`ifdef VEDIC_SIGNED_EN
        .op_signed(1'b0),
`endif
        .out_valid(o32), .out_ready(1'b1), .p(p32), .out_tag(t32)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out;
    logic        seen_in_ready;
    logic [15:0] exp_p [$];
    logic [3:0]  exp_t [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One cycle on the main DUT. Outputs are compared against the golden queue when a
    // transfer happens, and accepted inputs are pushed into it. Entered and left at posedge+1.
    task automatic cycle(input logic rdy, input logic drv, input logic [7:0] av,
                         input logic [7:0] bv, input logic [3:0] tv);
        logic [15:0] prod;
        out_ready = rdy;
        in_valid  = drv;
        a         = av;
        b         = bv;
        in_tag    = tv;
        #1;
        seen_in_ready = in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_p.size() == 0) begin
                check("extra_out", 1, 0);
            end else begin
                check("sb_p", p, exp_p.pop_front());
                check("sb_tag", out_tag, exp_t.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            prod = 16'(av) * 16'(bv);
            exp_p.push_back(prod);
            exp_t.push_back(tv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 10 && exp_p.size() != 0; k++) begin
            cycle(1'b1, 1'b0, 8'd0, 8'd0, 4'd0);
        end
        check(tag, exp_p.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] held_p;
        logic [3:0]  held_t;
        int          low_cnt;
        int          lat;
        logic [3:0]  ta4 [4];
        logic [3:0]  tb4 [4];
        logic [7:0]  tp4 [4];
        logic [15:0] ta16 [4];
        logic [15:0] tb16 [4];
        logic [31:0] tp16 [4];
        logic [31:0] ta32 [4];
        logic [31:0] tb32 [4];
        logic [63:0] tp32 [4];
        logic [7:0]  ca [6];
        logic [7:0]  cb [6];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; in_tag = '0;
        v4 = 1'b0; a4 = '0; b4 = '0; v16 = 1'b0; a16 = '0; b16 = '0;
        v32 = 1'b0; a32 = '0; b32 = '0;
`ifdef VEDIC_SIGNED_EN
        op_signed = 1'b0;
`endif
        step;
        check("rst_out_valid", out_valid, 0);
        check("rst_p", p, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        step;
        rst = 1'b0;

        // FF*FF with latency 3
        a = 8'hFF; b = 8'hFF; in_tag = 4'd5; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        check("t1_lat1", out_valid, 0);
        step;
        check("t1_lat2", out_valid, 0);
        step;
        check("t1_valid", out_valid, 1);
        check("t1_p", p, 16'hFE01);
        check("t1_tag", out_tag, 4'd5);
        step;
        check("t1_gone", out_valid, 0);

        // 256 back-to-back pairs
        n_out = 0;
        low_cnt = 0;
        for (int i = 0; i < 259; i++) begin
            if (i < 256) begin
                cycle(1'b1, 1'b1, 8'(i), 8'(255 - i), 4'(i));
                if (!seen_in_ready) low_cnt++;
            end else begin
                cycle(1'b1, 1'b0, 8'd0, 8'd0, 4'd0);
            end
        end
        check("t2_count", n_out, 256);
        check("t2_in_ready_low", low_cnt, 0);
        check("t2_left", exp_p.size(), 0);

        // Backpressure
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(10 + i), 8'(200 - i), 4'(i + 1));
        check("t3_full", out_valid, 1);
        held_p = p;
        held_t = out_tag;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'(50 + i), 8'(3 + i), 4'(8 + i));
            check("t3_in_ready", seen_in_ready, 0);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_p", p, held_p);
            check("t3_hold_tag", out_tag, held_t);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(90 + i), 8'(7 + i), 4'(13 + i));
        drain("t3_left");

        // Reset with three items in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(20 + i), 8'(30 + i), 4'(i));
        rst = 1'b1; in_valid = 1'b0;
        step;
        rst = 1'b0;
        check("t4_out_valid", out_valid, 0);
        check("t4_in_ready", in_ready, 1);
        exp_p.delete();
        exp_t.delete();
        n_out = 0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'd0, 8'd0, 4'd0);
        check("t4_stale", n_out, 0);
        cycle(1'b1, 1'b1, 8'd3, 8'd5, 4'd9);
        lat = 0;
        while (!out_valid && lat < 10) begin
            cycle(1'b1, 1'b0, 8'd0, 8'd0, 4'd0);
            lat++;
        end
        check("t4_latency", lat, 2);
        check("t4_p", p, 16'd15);
        drain("t4_left");

        // Corner operands, streamed
        ca[0] = 8'h00; cb[0] = 8'hAB;
        ca[1] = 8'hFF; cb[1] = 8'h01;
        ca[2] = 8'h01; cb[2] = 8'hFF;
        ca[3] = 8'h80; cb[3] = 8'h80;
        ca[4] = 8'hFF; cb[4] = 8'h00;
        ca[5] = 8'h0F; cb[5] = 8'hF0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, ca[i], cb[i], 4'(i));
        drain("t5_left");

        // Other widths: fixed latency and exact products
        ta4[0] = 4'h0; tb4[0] = 4'h9; tp4[0] = 8'h00;
        ta4[1] = 4'hF; tb4[1] = 4'hF; tp4[1] = 8'hE1;
        ta4[2] = 4'h1; tb4[2] = 4'hF; tp4[2] = 8'h0F;
        ta4[3] = 4'h9; tb4[3] = 4'h7; tp4[3] = 8'h3F;
        ta16[0] = 16'h0000; tb16[0] = 16'hFFFF; tp16[0] = 32'h0000_0000;
        ta16[1] = 16'hFFFF; tb16[1] = 16'hFFFF; tp16[1] = 32'hFFFE_0001;
        ta16[2] = 16'h0001; tb16[2] = 16'hFFFF; tp16[2] = 32'h0000_FFFF;
        ta16[3] = 16'h1234; tb16[3] = 16'h5678; tp16[3] = 32'h0626_0060;
        ta32[0] = 32'h0;          tb32[0] = 32'hFFFF_FFFF; tp32[0] = 64'h0;
        ta32[1] = 32'hFFFF_FFFF;  tb32[1] = 32'hFFFF_FFFF; tp32[1] = 64'hFFFF_FFFE_0000_0001;
        ta32[2] = 32'h1;          tb32[2] = 32'hFFFF_FFFF; tp32[2] = 64'h0000_0000_FFFF_FFFF;
        ta32[3] = 32'h0001_0000;  tb32[3] = 32'h0001_0000; tp32[3] = 64'h0000_0001_0000_0000;
        for (int v = 0; v < 4; v++) begin
            v4 = 1'b1;  a4 = ta4[v];   b4 = tb4[v];
            v16 = 1'b1; a16 = ta16[v]; b16 = tb16[v];
            v32 = 1'b1; a32 = ta32[v]; b32 = tb32[v];
            step;
            v4 = 1'b0; v16 = 1'b0; v32 = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                if (c == 1) check("w4_early", o4, 0);
                if (c == 2) begin
                    check("w4_valid", o4, 1);
                    check("w4_p", p4, tp4[v]);
                end
                if (c == 3) check("w16_early", o16, 0);
                if (c == 4) begin
                    check("w16_valid", o16, 1);
                    check("w16_p", p16, tp16[v]);
                    check("w32_early", o32, 0);
                end
                if (c == 5) begin
                    check("w32_valid", o32, 1);
                    check("w32_p", p32, tp32[v]);
                end
                if (c < 5) step;
            end
        end

`ifdef VEDIC_SIGNED_EN
        begin
            logic        sg [3];
            logic [7:0]  sa [3];
            logic [7:0]  sb [3];
            logic [15:0] sp [3];
            sg[0] = 1'b1; sa[0] = 8'h80; sb[0] = 8'h80; sp[0] = 16'h4000;
            sg[1] = 1'b1; sa[1] = 8'hFD; sb[1] = 8'h07; sp[1] = 16'hFFEB;
            sg[2] = 1'b0; sa[2] = 8'h80; sb[2] = 8'h02; sp[2] = 16'h0100;
            out_ready = 1'b1;
            for (int c = 1; c <= 5; c++) begin
                if (c <= 3) begin
                    in_valid = 1'b1; op_signed = sg[c-1]; a = sa[c-1]; b = sb[c-1];
                end else begin
                    in_valid = 1'b0; op_signed = 1'b0;
                end
                step;
                if (c >= 3) begin
                    check("s_valid", out_valid, 1);
                    check("s_p", p, sp[c-3]);
                end
            end
            in_valid = 1'b0;
            step;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
